// File: rtl/rsa_pkg.sv
// Shared constants for the RSA message sequencer: FSM state encoding and
// default message geometry.
package rsa_pkg;

  localparam int MSG_LEN_DEFAULT = 20;
  localparam int DEC_LAT_DEFAULT = 15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/latency_timer.sv
// 8-bit down-counter that paces the external decryptor; it saturates at
// zero instead of wrapping.
module latency_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/rsa_msg_sequencer.sv
// Feeds encrypted words one at a time to an external decryptor, waits the
// fixed decrypt latency, and hands each plaintext byte to the consumer.
module rsa_msg_sequencer
  import rsa_pkg::*;
#(
  parameter int MESSAGE_LENGTH = MSG_LEN_DEFAULT,
  parameter int DEC_LATENCY    = DEC_LAT_DEFAULT,
  parameter int CW             = $clog2(MESSAGE_LENGTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          in_ready,
  output logic [15:0]   dec_cipher,
  input  logic [7:0]    dec_plain,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] char_count
);

  // Loading LATENCY-1 makes out_valid rise exactly LATENCY edges after the
  // input handshake, since the emit edge itself is the one that sees zero.
  localparam logic [7:0]    LAT_LOAD   = 8'(DEC_LATENCY - 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(MESSAGE_LENGTH);

  logic [2:0]    r_state;
  logic [15:0]   r_cipher;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic [CW-1:0] r_count;

  logic          w_in_hs;
  logic          w_timer_dec;
  logic          w_timer_zero;
  logic [CW-1:0] w_count_inc;

  assign w_in_hs     = (r_state == ST_FETCH) && in_valid;
  assign w_timer_dec = (r_state == ST_WAIT);
  assign w_count_inc = r_count + CW'(1);

  latency_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_in_hs),
    .i_load_val (LAT_LOAD),
    .i_dec      (w_timer_dec),
    .o_zero     (w_timer_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cipher    <= 16'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_count <= '0;
          end
        end
        ST_FETCH: begin
          if (in_valid) begin
            r_cipher <= in_data;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_timer_zero) begin
            r_out_data  <= dec_plain;
            r_out_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_count     <= w_count_inc;
            r_state     <= (w_count_inc == LAST_COUNT) ? ST_DONE : ST_FETCH;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == ST_FETCH);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign dec_cipher = r_cipher;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign char_count = r_count;

endmodule
